reg_write_trace: RTL and testbench

REG_WRITE_TRACE -- requirements
Module: reg_write_trace

---
 rtl/reg_write_trace_if.sv | 37 +++
 rtl/reg_write_trace.sv | 136 +++++++++++++
 tb/tb_reg_write_trace.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_write_trace_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_trace_if
// Description : Bundle of the write-back capture port and the trace-stream
//               output port of the register write trace buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_write_trace_if #(
    parameter int STAMP_W = 16
);
    // Write-back side: one register-file write per committing instruction
    logic                wb_en;
    logic [4:0]          wb_addr;
    logic [31:0]         wb_data;
    logic [31:0]         wb_pc;

    // Trace side: valid/ready stream of captured writes
    logic                trace_valid;
    logic                trace_ready;
    logic [31:0]         trace_pc;
    logic [4:0]          trace_addr;
    logic [31:0]         trace_data;
    logic [STAMP_W-1:0]  trace_stamp;

    // Producer of write-backs and consumer of the trace stream
    modport master (
        output wb_en, wb_addr, wb_data, wb_pc, trace_ready,
        input  trace_valid, trace_pc, trace_addr, trace_data, trace_stamp
    );

    // The trace buffer itself
    modport slave (
        input  wb_en, wb_addr, wb_data, wb_pc, trace_ready,
        output trace_valid, trace_pc, trace_addr, trace_data, trace_stamp
    );
endinterface
`default_nettype wire

// File: rtl/reg_write_trace.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_trace
// Description : Captures qualified register-file writes (pc, addr, data,
//               cycle stamp) into a first-word-fall-through FIFO that is
//               drained through a valid/ready trace stream. Writes arriving
//               while the FIFO is full and not being drained are dropped and
//               recorded in a sticky overflow flag and a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_write_trace #(
    parameter int DEPTH   = 8,
    parameter int STAMP_W = 16
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    reg_write_trace_if.slave              bus,
    input  wire logic                     clr_ovf,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          overflow,
    output logic [7:0]                    drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_full_count = CNT_W'(DEPTH);
    localparam logic [7:0]       c_drop_max   = 8'hFF;

    typedef struct packed {
        logic [31:0]        pc;
        logic [4:0]         addr;
        logic [31:0]        data;
        logic [STAMP_W-1:0] stamp;
    } entry_t;

    entry_t              r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [STAMP_W-1:0]  r_stamp;
    logic                r_overflow;
    logic [7:0]          r_drop_cnt;

    logic                w_valid;
    logic                w_full;
    logic                w_qualified;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    entry_t              w_head;
    entry_t              w_new;

    // Handshake decode; full/empty come only from the occupancy count so a
    // pointer match is never ambiguous. A pop frees a slot in the same edge,
    // so a write into a full FIFO that is being drained is still accepted.
    always_comb begin
        w_valid     = (r_count != '0);
        w_full      = (r_count == c_full_count);
        w_qualified = bus.wb_en && (bus.wb_addr != 5'd0);
        w_pop       = w_valid && bus.trace_ready;
        w_push      = w_qualified && (!w_full || w_pop);
        w_drop      = w_qualified && w_full && !w_pop;
        w_head      = r_mem[r_rd_ptr];
        w_new       = '{pc: bus.wb_pc, addr: bus.wb_addr,
                        data: bus.wb_data, stamp: r_stamp};
    end

    // Entry storage; contents are meaningless until counted, so no reset
    always_ff @(posedge clk) begin
        if (w_push && rst_n) begin
            r_mem[r_wr_ptr] <= w_new;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Free-running cycle stamp, zero during the first cycle after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stamp <= '0;
        end else begin
            r_stamp <= r_stamp + 1'b1;
        end
    end

    // Drop bookkeeping; a drop on the same edge as a clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clr_ovf) begin
                r_drop_cnt <= 8'd1;
            end else if (r_drop_cnt != c_drop_max) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    // Head entry is presented directly; fields read as zero when empty,
    // which also makes them clear immediately on asynchronous reset
    assign bus.trace_valid = w_valid;
    assign bus.trace_pc    = w_valid ? w_head.pc    : '0;
    assign bus.trace_addr  = w_valid ? w_head.addr  : '0;
    assign bus.trace_data  = w_valid ? w_head.data  : '0;
    assign bus.trace_stamp = w_valid ? w_head.stamp : '0;

    assign count    = r_count;
    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_trace.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_write_trace
// Description : Self-checking bench for reg_write_trace: a vector table with
//               expected occupancy/overflow figures, a queue scoreboard for
//               the trace stream, and hand-written corner-case sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_write_trace;

    localparam int DEPTH   = 8;
    localparam int STAMP_W = 16;
    localparam int NVEC    = 19;

    typedef struct {
        logic [31:0]        pc;
        logic [4:0]         addr;
        logic [31:0]        data;
        logic [STAMP_W-1:0] stamp;
    } ent_t;

    typedef struct {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
        logic        ready;
        logic        clr;
        int          exp_count;
        logic        exp_ovf;
        int          exp_drop;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        clr_ovf;
    logic [3:0]  count;
    logic        overflow;
    logic [7:0]  drop_cnt;

    reg_write_trace_if #(.STAMP_W(STAMP_W)) bus ();

    reg_write_trace #(.DEPTH(DEPTH), .STAMP_W(STAMP_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .clr_ovf  (clr_ovf),
        .count    (count),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    // Reference state
    ent_t               sb[$];
    logic               m_ovf;
    int                 m_drop;
    logic [STAMP_W-1:0] m_stamp;

    int   checks;
    int   errors;
    vec_t vecs [NVEC];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [4:0] addr, input logic [31:0] data,
                         input logic [31:0] pc, input logic ready, input logic clr);
        bus.wb_en       = en;
        bus.wb_addr     = addr;
        bus.wb_data     = data;
        bus.wb_pc       = pc;
        bus.trace_ready = ready;
        clr_ovf         = clr;
    endtask

    // Compare every visible output against the reference state
    task automatic sample();
        chk("valid", bus.trace_valid, sb.size() != 0);
        chk("count", count, sb.size());
        chk("overflow", overflow, m_ovf);
        chk("drop_cnt", drop_cnt, m_drop);
        if (sb.size() != 0) begin
            chk("head_pc", bus.trace_pc, sb[0].pc);
            chk("head_addr", bus.trace_addr, sb[0].addr);
            chk("head_data", bus.trace_data, sb[0].data);
            chk("head_stamp", bus.trace_stamp, sb[0].stamp);
        end else begin
            chk("idle_fields_zero",
                {bus.trace_pc, bus.trace_addr, bus.trace_data, bus.trace_stamp}, 0);
        end
    endtask

    // Advance the reference by one rising edge using the driven inputs
    task automatic model_edge();
        bit pop, push, full, drop;
        pop  = (sb.size() != 0) && bus.trace_ready;
        push = bus.wb_en && (bus.wb_addr != 5'd0);
        full = (sb.size() == DEPTH);
        drop = push && full && !pop;
        if (pop) void'(sb.pop_front());
        if (push && !drop) sb.push_back('{bus.wb_pc, bus.wb_addr, bus.wb_data, m_stamp});
        if (drop) begin
            m_ovf  = 1'b1;
            m_drop = clr_ovf ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
        end else if (clr_ovf) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
        m_stamp = m_stamp + 1'b1;
    endtask

    task automatic model_reset();
        sb.delete();
        m_ovf   = 1'b0;
        m_drop  = 0;
        m_stamp = '0;
    endtask

    // One full cycle starting and ending 1 time unit after a rising edge
    task automatic cycle(input logic en, input logic [4:0] addr, input logic [31:0] data,
                         input logic [31:0] pc, input logic ready, input logic clr);
        drive(en, addr, data, pc, ready, clr);
        @(negedge clk);
        sample();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic en, input logic [4:0] addr, input logic [31:0] data,
                                input logic [31:0] pc, input logic ready, input logic clr,
                                input int ec, input logic eo, input int ed);
        vec_t v;
        v.en = en; v.addr = addr; v.data = data; v.pc = pc; v.ready = ready; v.clr = clr;
        v.exp_count = ec; v.exp_ovf = eo; v.exp_drop = ed;
        return v;
    endfunction

    initial begin
        logic [STAMP_W-1:0] last_stamp;
        bit                 have_last;

        checks = 0;
        errors = 0;

        // Single write, consume, $zero filter, overflow, clear, full+pop, drop vs clear
        vecs[0] = mk(1, 16, 32'h5, 32'h4, 0, 0, 1, 0, 0);
        vecs[1] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0);
        vecs[2] = mk(1, 0, 32'hFFFF_FFFF, 32'h10, 0, 0, 0, 0, 0);
        vecs[3] = mk(1, 0, 32'hFFFF_FFFF, 32'h14, 0, 0, 0, 0, 0);
        vecs[4] = mk(1, 0, 32'hFFFF_FFFF, 32'h18, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            vecs[5+i] = mk(1, 5'(i + 1), 32'hA000 + 32'(i), 32'h100 + 32'(4 * i), 0, 0,
                           (i < 8) ? i + 1 : 8, (i >= 8), (i >= 8) ? i - 7 : 0);
        end
        vecs[15] = mk(0, 0, 0, 0, 0, 1, 8, 0, 0);
        vecs[16] = mk(1, 20, 32'hBEEF, 32'h200, 1, 0, 8, 0, 0);
        vecs[17] = mk(1, 21, 32'hDEAD, 32'h204, 0, 1, 8, 1, 1);
        vecs[18] = mk(0, 0, 0, 0, 0, 1, 8, 0, 0);

        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        sample();
        chk("reset_stamp_field", bus.trace_stamp, 0);
        rst_n = 1'b1;

        // Table-driven section
        for (int v = 0; v < NVEC; v++) begin
            cycle(vecs[v].en, vecs[v].addr, vecs[v].data, vecs[v].pc, vecs[v].ready, vecs[v].clr);
            chk($sformatf("vec%0d_count", v), count, vecs[v].exp_count);
            chk($sformatf("vec%0d_overflow", v), overflow, vecs[v].exp_ovf);
            chk($sformatf("vec%0d_drop_cnt", v), drop_cnt, vecs[v].exp_drop);
            if (v == 0) begin
                chk("single_write_addr", bus.trace_addr, 16);
                chk("single_write_data", bus.trace_data, 32'h5);
                chk("single_write_pc", bus.trace_pc, 32'h4);
            end
            if (v == 14) chk("overflow_head_first", bus.trace_addr, 1);
        end

        // Drain: order must be writes 2..8 followed by the entry pushed while full
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1, 0);
        chk("drained_empty", count, 0);
        cycle(0, 0, 0, 0, 1, 0);

        // Stream with continuous ready: one-cycle latency, consecutive stamps
        have_last = 0;
        last_stamp = '0;
        for (int i = 0; i < 21; i++) begin
            drive(i < 20, 5'((i % 31) + 1), 32'h5000 + 32'(i), 32'h8000 + 32'(4 * i), 1, 0);
            @(negedge clk);
            sample();
            chk("stream_count_le1", count <= 1, 1);
            if (bus.trace_valid) begin
                if (have_last) chk("stream_stamp_step", bus.trace_stamp, last_stamp + 1'b1);
                last_stamp = bus.trace_stamp;
                have_last  = 1;
            end
            model_edge();
            @(posedge clk);
            #1;
        end
        cycle(0, 0, 0, 0, 0, 0);
        chk("stream_empty", count, 0);

        // Drop counter saturation
        for (int i = 0; i < 8 + 260; i++) begin
            cycle(1, 5'(i % 31 + 1), 32'(i), 32'h9000 + 32'(4 * i), 0, 0);
        end
        chk("drop_saturated", drop_cnt, 255);
        chk("drop_saturated_ovf", overflow, 1);

        // Bring occupancy to five, then reset between edges
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0);
        chk("pre_reset_count", count, 5);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_valid", bus.trace_valid, 0);
        chk("async_rst_count", count, 0);
        chk("async_rst_fields",
            {bus.trace_pc, bus.trace_addr, bus.trace_data, bus.trace_stamp}, 0);
        chk("async_rst_ovf", {overflow, drop_cnt}, 0);
        drive(1, 5, 32'h55, 32'h500, 0, 0);
        @(posedge clk);
        #1;
        chk("no_push_in_reset", count, 0);
        #2;
        rst_n = 1'b1;
        cycle(1, 7, 32'h77, 32'h700, 0, 0);
        chk("rst_first_stamp", bus.trace_stamp, 0);
        chk("rst_first_addr", bus.trace_addr, 7);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
